remove_pilot: RTL and testbench

Receive-side counterpart of the transmit pilot-insertion stage. It sits directly after the 64-point FFT. It takes one OFDM symbol as 64 bins in natural FFT order, discards the DC and guard nulls, and separates the 4 pilots from the 48 data subcarriers. Both outputs are re-emitted in ascending logical-frequency order (k = -26..26). A 2x64 ping-pong buffer lets symbol N be read out while symbol N+1 is written.

---
 rtl/remove_pilot.sv | 231 +++++++++++++++++++++++
 tb/tb_remove_pilot.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/remove_pilot.sv
// Receive-side pilot removal: buffers one 64-bin FFT symbol per bank and re-emits
// the 48 data and 4 pilot subcarriers in ascending logical frequency (k = -26..26).
module remove_pilot #(
    parameter int DATA_W = 16,
    parameter int NFFT   = 64
) (
    input  logic              depilot_clk,
    input  logic              depilot_rst,
    input  logic              din_valid,
    input  logic              din_sof,
    input  logic [DATA_W-1:0] din_real,
    input  logic [DATA_W-1:0] din_imag,
    output logic              dout_valid,
    output logic [5:0]        dout_index,
    output logic [DATA_W-1:0] dout_real,
    output logic [DATA_W-1:0] dout_imag,
    output logic              pilot_valid,
    output logic [1:0]        pilot_index,
    output logic [DATA_W-1:0] pilot_real,
    output logic [DATA_W-1:0] pilot_imag,
    output logic              sym_done
);
    localparam int SW = 2 * DATA_W;
    localparam logic [5:0] LAST_POS = 6'd51;

    typedef enum logic {S_IDLE, S_READ} state_t;

    // Ping-pong storage: address = {bank, bin}, word = {real, imag}
    logic [SW-1:0] ram [0:2*NFFT-1];
    logic [SW-1:0] rd_data_q;

    logic [5:0]  wcnt_q, wcnt_d;
    logic        wbank_q, wbank_d;
    logic [1:0]  full_q, full_d;
    state_t      state_q, state_d;
    logic        rbank_q, rbank_d;
    logic [5:0]  pos_q, pos_d;
    logic        s1_valid_q, s1_valid_d;
    logic [5:0]  s1_pos_q, s1_pos_d;

    logic              dout_valid_q, dout_valid_d;
    logic [5:0]        dout_index_q, dout_index_d;
    logic [DATA_W-1:0] dout_real_q, dout_real_d;
    logic [DATA_W-1:0] dout_imag_q, dout_imag_d;
    logic              pilot_valid_q, pilot_valid_d;
    logic [1:0]        pilot_index_q, pilot_index_d;
    logic [DATA_W-1:0] pilot_real_q, pilot_real_d;
    logic [DATA_W-1:0] pilot_imag_q, pilot_imag_d;
    logic              sym_done_q, sym_done_d;

    logic        wr_en;
    logic [5:0]  wr_addr;
    logic        set_full;
    logic        rd_en;
    logic        rd_bank;
    logic [5:0]  rd_pos;
    logic [5:0]  rd_addr;
    logic        clr_full;
    logic        other_bank;
    logic        pilot_hit;
    logic [1:0]  pilot_num;
    logic [5:0]  data_num;

    // Write side: din_sof restarts the current bank at bin 0
    always_comb begin
        wcnt_d   = wcnt_q;
        wbank_d  = wbank_q;
        wr_en    = 1'b0;
        wr_addr  = wcnt_q;
        set_full = 1'b0;
        if (din_valid) begin
            wr_en = 1'b1;
            if (din_sof) begin
                wr_addr = 6'd0;
                wcnt_d  = 6'd1;
            end else if (wcnt_q == 6'd63) begin
                set_full = 1'b1;
                wbank_d  = ~wbank_q;
                wcnt_d   = 6'd0;
            end else begin
                wcnt_d = wcnt_q + 6'd1;
            end
        end
    end

    // Reader: IDLE issues the first address itself so the burst starts one cycle earlier
    always_comb begin
        state_d    = state_q;
        rbank_d    = rbank_q;
        pos_d      = pos_q;
        rd_en      = 1'b0;
        rd_bank    = rbank_q;
        rd_pos     = pos_q;
        clr_full   = 1'b0;
        other_bank = ~rbank_q;
        case (state_q)
            S_IDLE: begin
                if (full_q != 2'b00) begin
                    rd_en   = 1'b1;
                    rd_bank = ~full_q[0];
                    rd_pos  = 6'd0;
                    rbank_d = ~full_q[0];
                    pos_d   = 6'd1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rd_en = 1'b1;
                if (pos_q == LAST_POS) begin
                    clr_full = 1'b1;
                    pos_d    = 6'd0;
                    if (full_q[other_bank]) begin
                        rbank_d = other_bank;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    pos_d = pos_q + 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Logical position 0..51 maps to k = -26..-1, 1..26; negative k live at bin 64+k
    assign rd_addr = (rd_pos < 6'd26) ? rd_pos + 6'd38 : rd_pos - 6'd25;

    always_comb begin
        full_d = full_q;
        if (clr_full) full_d[rbank_q] = 1'b0;
        if (set_full) full_d[wbank_q] = 1'b1;
        s1_valid_d = rd_en;
        s1_pos_d   = rd_en ? rd_pos : s1_pos_q;
    end

    // Pilots sit at positions 5, 19, 32, 46 (k = -21, -7, 7, 21)
    always_comb begin
        pilot_hit = 1'b0;
        pilot_num = 2'd0;
        case (s1_pos_q)
            6'd5:  begin pilot_hit = 1'b1; pilot_num = 2'd0; end
            6'd19: begin pilot_hit = 1'b1; pilot_num = 2'd1; end
            6'd32: begin pilot_hit = 1'b1; pilot_num = 2'd2; end
            6'd46: begin pilot_hit = 1'b1; pilot_num = 2'd3; end
            default: ;
        endcase
        if (s1_pos_q < 6'd5)       data_num = s1_pos_q;
        else if (s1_pos_q < 6'd19) data_num = s1_pos_q - 6'd1;
        else if (s1_pos_q < 6'd32) data_num = s1_pos_q - 6'd2;
        else if (s1_pos_q < 6'd46) data_num = s1_pos_q - 6'd3;
        else                       data_num = s1_pos_q - 6'd4;
    end

    always_comb begin
        dout_valid_d  = s1_valid_q & ~pilot_hit;
        pilot_valid_d = s1_valid_q & pilot_hit;
        sym_done_d    = s1_valid_q & (s1_pos_q == LAST_POS);
        dout_index_d  = dout_index_q;
        dout_real_d   = dout_real_q;
        dout_imag_d   = dout_imag_q;
        pilot_index_d = pilot_index_q;
        pilot_real_d  = pilot_real_q;
        pilot_imag_d  = pilot_imag_q;
        if (dout_valid_d) begin
            dout_index_d = data_num;
            dout_real_d  = rd_data_q[SW-1:DATA_W];
            dout_imag_d  = rd_data_q[DATA_W-1:0];
        end
        if (pilot_valid_d) begin
            pilot_index_d = pilot_num;
            pilot_real_d  = rd_data_q[SW-1:DATA_W];
            pilot_imag_d  = rd_data_q[DATA_W-1:0];
        end
    end

    always_ff @(posedge depilot_clk) begin
        if (wr_en) ram[{wbank_q, wr_addr}] <= {din_real, din_imag};
        rd_data_q <= ram[{rd_bank, rd_addr}];
    end

    always_ff @(posedge depilot_clk) begin
        if (depilot_rst) begin
            wcnt_q        <= '0;
            wbank_q       <= 1'b0;
            full_q        <= '0;
            state_q       <= S_IDLE;
            rbank_q       <= 1'b0;
            pos_q         <= '0;
            s1_valid_q    <= 1'b0;
            s1_pos_q      <= '0;
            dout_valid_q  <= 1'b0;
            dout_index_q  <= '0;
            dout_real_q   <= '0;
            dout_imag_q   <= '0;
            pilot_valid_q <= 1'b0;
            pilot_index_q <= '0;
            pilot_real_q  <= '0;
            pilot_imag_q  <= '0;
            sym_done_q    <= 1'b0;
        end else begin
            wcnt_q        <= wcnt_d;
            wbank_q       <= wbank_d;
            full_q        <= full_d;
            state_q       <= state_d;
            rbank_q       <= rbank_d;
            pos_q         <= pos_d;
            s1_valid_q    <= s1_valid_d;
            s1_pos_q      <= s1_pos_d;
            dout_valid_q  <= dout_valid_d;
            dout_index_q  <= dout_index_d;
            dout_real_q   <= dout_real_d;
            dout_imag_q   <= dout_imag_d;
            pilot_valid_q <= pilot_valid_d;
            pilot_index_q <= pilot_index_d;
            pilot_real_q  <= pilot_real_d;
            pilot_imag_q  <= pilot_imag_d;
            sym_done_q    <= sym_done_d;
        end
    end

    assign dout_valid  = dout_valid_q;
    assign dout_index  = dout_index_q;
    assign dout_real   = dout_real_q;
    assign dout_imag   = dout_imag_q;
    assign pilot_valid = pilot_valid_q;
    assign pilot_index = pilot_index_q;
    assign pilot_real  = pilot_real_q;
    assign pilot_imag  = pilot_imag_q;
    assign sym_done    = sym_done_q;

endmodule

// File: tb/tb_remove_pilot.sv
// Directed bench for remove_pilot: expected subcarrier order comes from a k-segment table.
module tb_remove_pilot;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          din_valid;
    logic          din_sof;
    logic [DW-1:0] din_real;
    logic [DW-1:0] din_imag;
    logic          dout_valid;
    logic [5:0]    dout_index;
    logic [DW-1:0] dout_real;
    logic [DW-1:0] dout_imag;
    logic          pilot_valid;
    logic [1:0]    pilot_index;
    logic [DW-1:0] pilot_real;
    logic [DW-1:0] pilot_imag;
    logic          sym_done;

    remove_pilot #(.DATA_W(DW), .NFFT(64)) dut (
        .depilot_clk (clk),
        .depilot_rst (rst),
        .din_valid   (din_valid),
        .din_sof     (din_sof),
        .din_real    (din_real),
        .din_imag    (din_imag),
        .dout_valid  (dout_valid),
        .dout_index  (dout_index),
        .dout_real   (dout_real),
        .dout_imag   (dout_imag),
        .pilot_valid (pilot_valid),
        .pilot_index (pilot_index),
        .pilot_real  (pilot_real),
        .pilot_imag  (pilot_imag),
        .sym_done    (sym_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kf;
        int kl;
        bit pilot;
        int idx0;
    } seg_t;

    typedef struct {
        int k;
        int bin;
        bit pilot;
        int idx;
        bit done;
    } exp_t;

    typedef struct {
        int            cyc;
        bit            pilot;
        int            idx;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        bit            done;
        bit            bad;
    } rec_t;

    seg_t segs [10];
    exp_t exp_tab [52];
    rec_t obs [$];

    int cyc = 0;
    int done_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rec_t r;
        if (dout_valid || pilot_valid || sym_done) begin
            r.cyc   = cyc;
            r.pilot = pilot_valid;
            r.idx   = pilot_valid ? int'(pilot_index) : int'(dout_index);
            r.re    = pilot_valid ? pilot_real : dout_real;
            r.im    = pilot_valid ? pilot_imag : dout_imag;
            r.done  = sym_done;
            r.bad   = (dout_valid && pilot_valid) || (sym_done && !dout_valid);
            obs.push_back(r);
        end
        if (sym_done) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input bit ok, input string name, input string detail);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic check_zero(input string name);
        bit ok;
        ok = !dout_valid && dout_index == 0 && dout_real == 0 && dout_imag == 0 &&
             !pilot_valid && pilot_index == 0 && pilot_real == 0 && pilot_imag == 0 && !sym_done;
        check(ok, name, $sformatf("dv=%0b di=%0d dr=%0d pv=%0b pi=%0d pr=%0d done=%0b, required all 0",
              dout_valid, dout_index, dout_real, pilot_valid, pilot_index, pilot_real, sym_done));
    endtask

    task automatic send_symbol(input int base, input bit gap, input int nbins, output int cap);
        cap = -1;
        for (int n = 0; n < nbins; n++) begin
            din_valid = 1'b1;
            din_sof   = (n == 0);
            din_real  = DW'(base + n);
            din_imag  = DW'(-(base + n));
            @(posedge clk);
            #1;
            if (n == 63) cap = cyc;
            din_valid = 1'b0;
            din_sof   = 1'b0;
            if (gap && n != nbins - 1) tick(1);
        end
    endtask

    // Pops n records and compares each against the table; full bursts also check the mix.
    task automatic check_burst(input string name, input int base, input int cap, input int n);
        rec_t r;
        exp_t e;
        logic [DW-1:0] ere, eim;
        int nd, np;
        nd = 0;
        np = 0;
        for (int i = 0; i < n; i++) begin
            e = exp_tab[i];
            ere = DW'(base + e.bin);
            eim = DW'(-(base + e.bin));
            if (obs.size() == 0) begin
                check(1'b0, name, $sformatf("k=%0d no output seen, required real %0d at cycle %0d",
                      e.k, ere, cap + 2 + i));
            end else begin
                r = obs.pop_front();
                if (r.pilot) np++; else nd++;
                check(r.cyc == cap + 2 + i && r.pilot == e.pilot && r.idx == e.idx &&
                      r.re == ere && r.im == eim && r.done == e.done && !r.bad, name,
                      $sformatf("k=%0d got cyc=%0d pilot=%0b idx=%0d re=%0d im=%0d done=%0b bad=%0b; required cyc=%0d pilot=%0b idx=%0d re=%0d im=%0d done=%0b",
                      e.k, r.cyc, r.pilot, r.idx, $signed(r.re), $signed(r.im), r.done, r.bad,
                      cap + 2 + i, e.pilot, e.idx, $signed(ere), $signed(eim), e.done));
            end
        end
        if (n == 52) begin
            check(nd == 48 && np == 4, {name, "_count"},
                  $sformatf("got %0d data %0d pilot, required 48 data 4 pilot", nd, np));
        end
    endtask

    initial begin
        int i;
        int cap;
        int caps [3];
        int pending;

        segs[0] = '{-26, -22, 1'b0, 0};
        segs[1] = '{-21, -21, 1'b1, 0};
        segs[2] = '{-20,  -8, 1'b0, 5};
        segs[3] = '{ -7,  -7, 1'b1, 1};
        segs[4] = '{ -6,  -1, 1'b0, 18};
        segs[5] = '{  1,   6, 1'b0, 24};
        segs[6] = '{  7,   7, 1'b1, 2};
        segs[7] = '{  8,  20, 1'b0, 30};
        segs[8] = '{ 21,  21, 1'b1, 3};
        segs[9] = '{ 22,  26, 1'b0, 43};
        i = 0;
        for (int s = 0; s < 10; s++) begin
            for (int k = segs[s].kf; k <= segs[s].kl; k++) begin
                exp_tab[i] = '{k, (k < 0) ? 64 + k : k, segs[s].pilot,
                               segs[s].idx0 + (k - segs[s].kf), (k == 26)};
                i++;
            end
        end

        rst = 1'b1;
        din_valid = 1'b0;
        din_sof = 1'b0;
        din_real = '0;
        din_imag = '0;
        tick(3);
        check_zero("reset_outputs");
        rst = 1'b0;
        tick(2);

        // Ramp symbol
        send_symbol(0, 1'b0, 64, cap);
        tick(60);
        check_burst("ramp", 0, cap, 52);
        check(obs.size() == 0, "ramp_extra", $sformatf("got %0d extra outputs, required 0", obs.size()));

        // Three back-to-back symbols
        for (int s = 0; s < 3; s++) send_symbol(100 * (s + 1), 1'b0, 64, caps[s]);
        tick(60);
        for (int s = 0; s < 3; s++) check_burst($sformatf("b2b%0d", s), 100 * (s + 1), caps[s], 52);

        // din_valid toggling every other cycle
        send_symbol(400, 1'b1, 64, cap);
        tick(60);
        check_burst("gapped", 400, cap, 52);

        // Partial symbol abandoned by a new din_sof on its 20th bin
        send_symbol(500, 1'b0, 19, cap);
        send_symbol(600, 1'b0, 64, cap);
        tick(60);
        check_burst("sof_restart", 600, cap, 52);
        check(obs.size() == 0, "sof_extra", $sformatf("got %0d extra outputs, required 0", obs.size()));

        // Reset at read cycle 10
        send_symbol(700, 1'b0, 64, cap);
        tick(11);
        rst = 1'b1;
        tick(1);
        check_zero("midread_reset");
        rst = 1'b0;
        check_burst("pre_reset", 700, cap, 10);
        tick(70);
        pending = obs.size();
        check(pending == 0, "aborted_quiet", $sformatf("got %0d outputs after reset, required 0", pending));
        obs.delete();
        send_symbol(800, 1'b0, 64, cap);
        tick(60);
        check_burst("post_reset", 800, cap, 52);

        // Idle afterwards
        tick(150);
        check(obs.size() == 0, "idle_quiet", $sformatf("got %0d outputs while idle, required 0", obs.size()));
        check(!dout_valid && !pilot_valid && !sym_done, "idle_flags",
              $sformatf("dv=%0b pv=%0b done=%0b, required 0", dout_valid, pilot_valid, sym_done));
        check(done_cnt == 7, "sym_done_total", $sformatf("got %0d pulses, required 7", done_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
